count_ones_sequencer: RTL and testbench
=======================================

Name: count_ones_sequencer

Overview:
- Multi-cycle population counter for wide vectors.
- Accepts one DATA_WIDTH operand over a valid/ready handshake and counts it CHUNK_WIDTH bits per cycle using a single combinational count-ones datapath.
- Accumulates the per-chunk counts and returns the total over a second valid/ready handshake.
- Used where a full-width single-cycle popcount is too large or too slow, e.g. allocator free-slot counting and mask statistics.

Parameters:
- DATA_WIDTH, 32, width of the input vector; must be >= 1.
- CHUNK_WIDTH, 8, bits counted per cycle; 1 <= CHUNK_WIDTH <= DATA_WIDTH.
- NUM_CHUNKS, ceil(DATA_WIDTH/CHUNK_WIDTH), derived; do not override.
- COUNT_WIDTH, CLOG2(DATA_WIDTH+1), derived; width of the result, holds DATA_WIDTH exactly.

Ports:
- clock  input  1  system clock, rising edge.
- resetn  input  1  asynchronous active-low reset.
- in_valid  input  1  operand valid.
- in_ready  output  1  block can accept an operand.
- in_data  input  DATA_WIDTH  operand to count.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- out_count  output  COUNT_WIDTH  number of set bits in the accepted operand.
- busy  output  1  high in BUSY or DONE.

Behaviour:
- Reset (async assert on resetn low, sync deassert handled upstream):
  - state=IDLE, in_ready=1, out_valid=0, out_count=0, busy=0.
  - Shift register, accumulator and chunk counter cleared.
- States: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: load in_data into a shift register zero-extended to NUM_CHUNKS*CHUNK_WIDTH bits.
  - Clear accumulator, chunk index=0, go BUSY.
  - The pad bits are never counted.
- BUSY:
  - in_ready=0.
  - Each cycle: count ones in the low CHUNK_WIDTH bits of the shift register (per-chunk result width CLOG2(CHUNK_WIDTH+1)).
  - Add the zero-extended chunk count to the accumulator.
  - Shift right by CHUNK_WIDTH and increment the chunk index.
  - After the cycle processing chunk NUM_CHUNKS-1, go DONE.
  - The accumulator never overflows because COUNT_WIDTH holds DATA_WIDTH.
- DONE:
  - out_valid=1, out_count=accumulator.
  - Both are held stable until out_ready.
  - On out_valid&out_ready, go IDLE next cycle with out_valid=0.
  - out_count keeps its last value; it is don't-care while out_valid=0.
- Latency and throughput:
  - Operand accepted at edge T; out_valid rises at edge T+NUM_CHUNKS.
  - in_ready=0 from the accept cycle until the output handshake completes.
  - Minimum spacing between accepts is NUM_CHUNKS+2 cycles.
- in_valid in BUSY/DONE: ignored. Upstream holds it, per standard valid/ready rules.
- NUM_CHUNKS=1: a single BUSY cycle, then DONE.
- resetn asserted mid-BUSY or in DONE: immediate return to reset values; the in-flight operand is discarded and no result is produced.
- out_ready held high in IDLE/BUSY: no effect.

Optional Feature:
- Macro: COUNT_ONES_SEQUENCER_EARLY_EXIT_EN.
- Defined:
  - In BUSY, if the shift register bits above the current chunk are all zero, go DONE after the current cycle.
  - out_count is identical to the non-early-exit result.
  - Latency is k+1 cycles, where k is the index of the highest chunk containing a set bit; 1 cycle for an all-zero operand.
- Not defined: fixed latency of NUM_CHUNKS cycles regardless of data.

Test Plan:
- DATA_WIDTH=32, CHUNK_WIDTH=8, in_data=0xFFFFFFFF, out_ready=1 -> out_valid 4 cycles after accept, out_count=32, in_ready low until the cycle after the output handshake.
- in_data=0x00000000 -> out_count=0. Latency is 4 cycles without the macro, 1 cycle with COUNT_ONES_SEQUENCER_EARLY_EXIT_EN.
- in_data=0x8000_0101 -> out_count=3. With the macro, latency stays 4 because the top chunk is nonzero; in_data=0x0000_0101 gives count 2 in 2 cycles.
- Backpressure: result ready, out_ready low for 5 cycles with in_valid high -> out_valid and out_count stable, in_ready=0, no second accept; on out_ready=1 the handshake completes and the next operand is accepted one cycle later.
- DATA_WIDTH=10, CHUNK_WIDTH=4, in_data=0x3FF -> NUM_CHUNKS=3, out_count=10 (COUNT_WIDTH=4), pad bits not counted.
- resetn pulsed low during the 2nd BUSY cycle -> all outputs return to reset values immediately, no out_valid; a new operand 0x0000000F after reset gives out_count=4.

Source files
------------

// File: rtl/count_ones_sequencer_if.sv
// Operand/result handshake bundle for count_ones_sequencer.
// The master drives operands and accepts results; the slave is the counter.
interface count_ones_sequencer_if #(
    parameter int DATA_WIDTH = 32
) ();
    localparam int COUNT_WIDTH = $clog2(DATA_WIDTH + 1);

    logic                   in_valid;
    logic                   in_ready;
    logic [DATA_WIDTH-1:0]  in_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [COUNT_WIDTH-1:0] out_count;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_count
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_count
    );
endinterface

// File: rtl/count_ones_sequencer.sv
// Multi-cycle popcount: counts CHUNK_WIDTH bits per cycle through one shared datapath.
// Define COUNT_ONES_SEQUENCER_EARLY_EXIT_EN to finish as soon as the remaining chunks are all zero.
module count_ones_sequencer #(
    parameter int DATA_WIDTH  = 32,
    parameter int CHUNK_WIDTH = 8
) (
    input  logic                   clock,
    input  logic                   resetn,
    count_ones_sequencer_if.slave  bus,
    output logic                   busy
);
    localparam int NUM_CHUNKS  = (DATA_WIDTH + CHUNK_WIDTH - 1) / CHUNK_WIDTH;
    localparam int PAD_WIDTH   = NUM_CHUNKS * CHUNK_WIDTH;
    localparam int COUNT_WIDTH = $clog2(DATA_WIDTH + 1);
    localparam int CHUNK_CNT_W = $clog2(CHUNK_WIDTH + 1);
    localparam int IDX_W       = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                 state, state_next;
    logic [PAD_WIDTH-1:0]   shreg;
    logic [COUNT_WIDTH-1:0] acc;
    logic [COUNT_WIDTH-1:0] acc_next;
    logic [COUNT_WIDTH-1:0] result;
    logic [IDX_W-1:0]       idx;
    logic [CHUNK_CNT_W-1:0] chunk_cnt;
    logic                   last_chunk;

    // Count ones in the chunk currently sitting at the bottom of the shift register.
    always_comb begin
        chunk_cnt = '0;
        for (int i = 0; i < CHUNK_WIDTH; i++) begin
            chunk_cnt = chunk_cnt + CHUNK_CNT_W'(shreg[i]);
        end
    end

    assign acc_next = acc + COUNT_WIDTH'(chunk_cnt);

`ifdef COUNT_ONES_SEQUENCER_EARLY_EXIT_EN
    assign last_chunk = (idx == IDX_W'(NUM_CHUNKS - 1)) || ((shreg >> CHUNK_WIDTH) == '0);
`else
    assign last_chunk = (idx == IDX_W'(NUM_CHUNKS - 1));
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_next;
    end

    // NOTE: every output of a combinational block gets a default first so no
    // path through the case leaves it unassigned and infers a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE: if (bus.in_valid)  state_next = BUSY;
            BUSY: if (last_chunk)    state_next = DONE;
            DONE: if (bus.out_ready) state_next = IDLE;
            default:                 state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        busy          = 1'b0;
        unique case (state)
            IDLE:    bus.in_ready  = 1'b1;
            BUSY:    busy          = 1'b1;
            DONE: begin
                bus.out_valid = 1'b1;
                busy          = 1'b1;
            end
            default: bus.in_ready  = 1'b1;
        endcase
    end

    assign bus.out_count = result;

    // The result register is separate from the accumulator so out_count keeps
    // its last value while the next operand is being counted.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            shreg  <= '0;
            acc    <= '0;
            idx    <= '0;
            result <= '0;
        end else begin
            unique case (state)
                IDLE: if (bus.in_valid) begin
                    shreg <= PAD_WIDTH'(bus.in_data);
                    acc   <= '0;
                    idx   <= '0;
                end
                BUSY: begin
                    acc   <= acc_next;
                    shreg <= shreg >> CHUNK_WIDTH;
                    idx   <= idx + IDX_W'(1);
                    if (last_chunk) result <= acc_next;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_count_ones_sequencer.sv
// Scoreboard bench for count_ones_sequencer: a 32/8 instance and a 10/4 instance.
// Drivers queue expected count and latency; monitors check at each result handshake.
module tb_count_ones_sequencer;
    logic clock = 1'b0;
    logic resetn = 1'b0;
    logic busy, nbusy;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    int   last_hs = 0;

    typedef struct {
        int count;
        int lat;
        int acc_edge;
    } exp_t;

    exp_t q[$];
    exp_t nq[$];
    bit   seen = 1'b0;
    bit   nseen = 1'b0;

    count_ones_sequencer_if #(.DATA_WIDTH(32)) bus ();
    count_ones_sequencer_if #(.DATA_WIDTH(10)) nbus ();

    count_ones_sequencer #(.DATA_WIDTH(32), .CHUNK_WIDTH(8)) dut (
        .clock(clock), .resetn(resetn), .bus(bus.slave), .busy(busy));
    count_ones_sequencer #(.DATA_WIDTH(10), .CHUNK_WIDTH(4)) ndut (
        .clock(clock), .resetn(resetn), .bus(nbus.slave), .busy(nbusy));

    always #5 clock = ~clock;
    always @(posedge clock) cyc++;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int pick_lat(input int fixed, input int early);
`ifdef COUNT_ONES_SEQUENCER_EARLY_EXIT_EN
        return early;
`else
        return fixed;
`endif
    endfunction

    // Wide-instance monitor: latency on the rising edge of out_valid, value and
    // stability every cycle it is held, pop on the handshake.
    always @(negedge clock) begin
        if (resetn && bus.out_valid) begin
            if (!seen) begin
                seen = 1'b1;
                if (q.size() == 0) check("unexpected_out_valid", 1, 0);
                else check("latency", cyc - q[0].acc_edge, q[0].lat);
            end
            if (q.size() != 0) begin
                check("out_count", bus.out_count, q[0].count);
                if (!bus.out_ready) begin
                    check("in_ready_while_held", bus.in_ready, 0);
                    check("busy_while_held", busy, 1);
                end else begin
                    last_hs = cyc + 1;
                    void'(q.pop_front());
                    seen = 1'b0;
                end
            end
        end
    end

    always @(negedge clock) begin
        if (resetn && nbus.out_valid) begin
            if (!nseen) begin
                nseen = 1'b1;
                if (nq.size() == 0) check("narrow_unexpected_out_valid", 1, 0);
                else check("narrow_latency", cyc - nq[0].acc_edge, nq[0].lat);
            end
            if (nq.size() != 0 && nbus.out_ready) begin
                check("narrow_out_count", nbus.out_count, nq[0].count);
                void'(nq.pop_front());
                nseen = 1'b0;
            end
        end
    end

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic send(input logic [31:0] d, input int cnt, input int lat,
                        input bit push, output int acc_edge);
        int guard = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        while (!bus.in_ready) begin
            @(negedge clock);
            guard++;
            if (guard > 200) begin
                $display("FAIL accept_timeout: in_ready stuck low, expected high within 200 cycles");
                $fatal(1, "accept timeout");
            end
        end
        acc_edge = cyc + 1;
        if (push) q.push_back('{count: cnt, lat: lat, acc_edge: acc_edge});
        @(negedge clock);
        bus.in_valid = 1'b0;
    endtask

    task automatic nsend(input logic [9:0] d, input int cnt, input int lat);
        int guard = 0;
        nbus.in_valid = 1'b1;
        nbus.in_data  = d;
        while (!nbus.in_ready) begin
            @(negedge clock);
            guard++;
            if (guard > 200) begin
                $display("FAIL narrow_accept_timeout: in_ready stuck low, expected high");
                $fatal(1, "accept timeout");
            end
        end
        nq.push_back('{count: cnt, lat: lat, acc_edge: cyc + 1});
        @(negedge clock);
        nbus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        while (q.size() != 0 || nq.size() != 0) begin
            @(negedge clock);
            guard++;
            if (guard > 300) begin
                check("drain_timeout", q.size() + nq.size(), 0);
                q.delete();
                nq.delete();
            end
        end
        @(negedge clock);
    endtask

    typedef struct {
        logic [31:0] data;
        int          cnt;
        int          lat_fixed;
        int          lat_early;
    } vec_t;

    vec_t vecs[7] = '{
        '{32'hFFFF_FFFF, 32, 4, 4},
        '{32'h0000_0000,  0, 4, 1},
        '{32'h8000_0101,  3, 4, 4},
        '{32'h0000_0101,  2, 4, 2},
        '{32'h0000_F00F,  8, 4, 2},
        '{32'h00FF_0000,  8, 4, 3},
        '{32'h1234_5678, 13, 4, 4}
    };

    initial begin
        int ae;
        int b_edge;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b1;
        nbus.in_valid  = 1'b0;
        nbus.in_data   = '0;
        nbus.out_ready = 1'b1;

        #1;
        check("reset_in_ready", bus.in_ready, 1);
        check("reset_out_valid", bus.out_valid, 0);
        check("reset_out_count", bus.out_count, 0);
        check("reset_busy", busy, 0);
        @(negedge clock);
        resetn = 1'b1;
        @(negedge clock);

        foreach (vecs[i]) begin
            send(vecs[i].data, vecs[i].cnt, pick_lat(vecs[i].lat_fixed, vecs[i].lat_early), 1'b1, ae);
            drain();
        end

        // Backpressure: result held 5 cycles while the next operand waits with in_valid high.
        bus.out_ready = 1'b0;
        send(32'hA5A5_A5A5, 16, 4, 1'b1, ae);
        fork
            begin
                send(32'h0000_0003, 2, pick_lat(4, 1), 1'b1, b_edge);
            end
            begin
                int guard = 0;
                while (!bus.out_valid && guard < 50) begin
                    @(negedge clock);
                    guard++;
                end
                check("backpressure_valid_seen", bus.out_valid, 1);
                repeat (5) @(negedge clock);
                bus.out_ready = 1'b1;
            end
        join
        check("accept_after_handshake", b_edge, last_hs + 1);
        drain();

        // Reset during the second BUSY cycle discards the in-flight operand.
        send(32'hFFFF_0000, 16, 4, 1'b0, ae);
        @(negedge clock);
        check("busy_before_reset", busy, 1);
        resetn = 1'b0;
        #1;
        check("midreset_in_ready", bus.in_ready, 1);
        check("midreset_out_valid", bus.out_valid, 0);
        check("midreset_busy", busy, 0);
        check("midreset_out_count", bus.out_count, 0);
        @(negedge clock);
        resetn = 1'b1;
        repeat (6) @(negedge clock);
        send(32'h0000_000F, 4, pick_lat(4, 1), 1'b1, ae);
        drain();

        // Narrow instance: 3 chunks of 4 bits, top two pad bits never counted.
        nsend(10'h3FF, 10, 3);
        drain();
        nsend(10'h0FF, 8, pick_lat(3, 2));
        drain();
        nsend(10'h200, 1, 3);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at 200000, expected done");
        $fatal(1, "global timeout");
    end
endmodule
